// File: rtl/reg_file_param.sv
// Parametrised register file: one write port, two combinational read ports,
// optional hardwired zero entry and write-to-read bypass, reset-driven clear sequencer.

module reg_file_rd_port #(
   parameter int DATA_W   = 32,
   parameter int ADDR_W   = 5,
   parameter bit ZERO_REG = 1'b1,
   parameter bit BYPASS   = 1'b1
) (
   input  logic              busy,
   input  logic [ADDR_W-1:0] addr,
   input  logic [DATA_W-1:0] entry,
   input  logic              wr_en,
   input  logic [ADDR_W-1:0] wr_addr,
   input  logic [DATA_W-1:0] wr_data,
   output logic [DATA_W-1:0] data
);
   // Busy masks everything, the zero entry beats bypass, bypass beats storage.
   always_comb begin
      data = entry;
      if (busy)
         data = '0;
      else if (ZERO_REG && (addr == '0))
         data = '0;
      else if (BYPASS && wr_en && (wr_addr == addr))
         data = wr_data;
   end
endmodule

module reg_file_param #(
   parameter int DATA_W   = 32,
   parameter int ADDR_W   = 5,
   parameter bit ZERO_REG = 1'b1,
   parameter bit BYPASS   = 1'b1
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              wr_en,
   input  logic [ADDR_W-1:0] wr_addr,
   input  logic [DATA_W-1:0] wr_data,
   input  logic [ADDR_W-1:0] rd_addr1,
   input  logic [ADDR_W-1:0] rd_addr2,
   output logic [DATA_W-1:0] rd_data1,
   output logic [DATA_W-1:0] rd_data2,
   output logic              init_busy
);
   localparam int       DEPTH     = 1 << ADDR_W;
   localparam int       NUM_PORTS = 2;
   localparam logic [0:0] CLEAR   = 1'b0;
   localparam logic [0:0] READY   = 1'b1;

   logic [0:0]        state;
   logic [ADDR_W-1:0] clr_ptr;
   logic [DATA_W-1:0] mem [DEPTH];

   logic              mem_we;
   logic [ADDR_W-1:0] mem_addr;
   logic [DATA_W-1:0] mem_data;

   logic [NUM_PORTS-1:0][ADDR_W-1:0] rd_addr;
   logic [NUM_PORTS-1:0][DATA_W-1:0] rd_data;

   assign init_busy = (state == CLEAR);

   // The pointer wraps to 0 on the final clear edge and then idles in READY.
   always_ff @(posedge clk) begin
      if (reset) begin
         state   <= CLEAR;
         clr_ptr <= '0;
      end else if (state == CLEAR) begin
         clr_ptr <= clr_ptr + 1'b1;
         if (clr_ptr == ADDR_W'(DEPTH - 1))
            state <= READY;
      end
   end

   // Single write mux: the clear sequencer owns the port while busy, so user
   // writes in that window are simply dropped.
   always_comb begin
      mem_we   = 1'b0;
      mem_addr = wr_addr;
      mem_data = wr_data;
      if (!reset) begin
         if (state == CLEAR) begin
            mem_we   = 1'b1;
            mem_addr = clr_ptr;
            mem_data = '0;
         end else if (wr_en && !(ZERO_REG && (wr_addr == '0))) begin
            mem_we = 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (mem_we)
         mem[mem_addr] <= mem_data;
   end

   assign rd_addr[0] = rd_addr1;
   assign rd_addr[1] = rd_addr2;

   for (genvar p = 0; p < NUM_PORTS; p++) begin : g_rd
      reg_file_rd_port #(
         .DATA_W  (DATA_W),
         .ADDR_W  (ADDR_W),
         .ZERO_REG(ZERO_REG),
         .BYPASS  (BYPASS)
      ) u_port (
         .busy   (init_busy),
         .addr   (rd_addr[p]),
         .entry  (mem[rd_addr[p]]),
         .wr_en  (wr_en),
         .wr_addr(wr_addr),
         .wr_data(wr_data),
         .data   (rd_data[p])
      );
   end

   assign rd_data1 = rd_data[0];
   assign rd_data2 = rd_data[1];
endmodule

// File: tb/tb_reg_file_param.sv
// Scoreboard bench for reg_file_param: one bypassing and one non-bypassing
// instance share stimulus; expectations come from a behavioural model.

module tb_reg_file_param;
   localparam int DW    = 32;
   localparam int AW    = 5;
   localparam int DEPTH = 1 << AW;

   logic          clk = 1'b0;
   logic          reset;
   logic          wr_en;
   logic [AW-1:0] wr_addr;
   logic [DW-1:0] wr_data;
   logic [AW-1:0] rd_addr1, rd_addr2;
   logic [DW-1:0] rd_data1, rd_data2, nb_data1, nb_data2;
   logic          init_busy, nb_busy;

   int checks = 0;
   int errors = 0;

   logic [DW-1:0] m_mem [DEPTH];
   logic          m_busy;
   logic [AW-1:0] m_ptr;

   string         tag_q [$];
   logic [DW-1:0] exp_q [$];

   always #5 clk = ~clk;

   reg_file_param #(.DATA_W(DW), .ADDR_W(AW), .ZERO_REG(1'b1), .BYPASS(1'b1)) dut (
      .clk(clk), .reset(reset), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
      .rd_addr1(rd_addr1), .rd_addr2(rd_addr2), .rd_data1(rd_data1), .rd_data2(rd_data2),
      .init_busy(init_busy)
   );

   reg_file_param #(.DATA_W(DW), .ADDR_W(AW), .ZERO_REG(1'b1), .BYPASS(1'b0)) dut_nb (
      .clk(clk), .reset(reset), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
      .rd_addr1(rd_addr1), .rd_addr2(rd_addr2), .rd_data1(nb_data1), .rd_data2(nb_data2),
      .init_busy(nb_busy)
   );

   task automatic chk(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   function automatic logic [DW-1:0] m_rd(input logic [AW-1:0] a, input bit byp);
      if (m_busy)                               return '0;
      if (a == '0)                              return '0;
      if (byp && wr_en && (wr_addr == a))       return wr_data;
      return m_mem[a];
   endfunction

   // One clock: queue expectations, compare at negedge, advance the model at posedge.
   task automatic cyc();
      logic [DW-1:0] got [5];
      tag_q.push_back("busy");   exp_q.push_back({{(DW-1){1'b0}}, m_busy});
      tag_q.push_back("rd1");    exp_q.push_back(m_rd(rd_addr1, 1'b1));
      tag_q.push_back("rd2");    exp_q.push_back(m_rd(rd_addr2, 1'b1));
      tag_q.push_back("nb_rd1"); exp_q.push_back(m_rd(rd_addr1, 1'b0));
      tag_q.push_back("nb_rd2"); exp_q.push_back(m_rd(rd_addr2, 1'b0));
      @(negedge clk);
      got[0] = {{(DW-1){1'b0}}, init_busy};
      got[1] = rd_data1;
      got[2] = rd_data2;
      got[3] = nb_data1;
      got[4] = nb_data2;
      for (int i = 0; i < 5; i++) chk(tag_q.pop_front(), got[i], exp_q.pop_front());
      @(posedge clk);
      if (reset) begin
         m_busy = 1'b1;
         m_ptr  = '0;
      end else if (m_busy) begin
         m_mem[m_ptr] = '0;
         if (m_ptr == AW'(DEPTH - 1)) m_busy = 1'b0;
         m_ptr = m_ptr + 1'b1;
      end else if (wr_en && (wr_addr != '0)) begin
         m_mem[wr_addr] = wr_data;
      end
      #1;
   endtask

   task automatic set_in(input logic we, input logic [AW-1:0] wa, input logic [DW-1:0] wd,
                         input logic [AW-1:0] a1, input logic [AW-1:0] a2);
      wr_en = we; wr_addr = wa; wr_data = wd; rd_addr1 = a1; rd_addr2 = a2;
   endtask

   // Runs cycles until init_busy drops (bounded) and checks the clear length.
   task automatic count_clear(input string tag);
      int n = 0;
      while (init_busy && n < DEPTH + 8) begin
         cyc();
         n++;
      end
      chk(tag, DW'(n), DW'(DEPTH));
   endtask

   initial begin
      set_in(1'b0, '0, '0, '0, '0);
      reset = 1'b1;
      @(posedge clk); #1;
      m_busy = 1'b1;
      m_ptr  = '0;

      // Reset held for two cycles; outputs must sit at reset values.
      cyc();
      cyc();
      reset = 1'b0;

      // Write attempted during clear, read addresses pointing at it.
      set_in(1'b1, 5'd3, 32'hAAAA5555, 5'd3, 5'd3);
      count_clear("clr_len");
      set_in(1'b0, '0, '0, 5'd3, 5'd3);
      cyc();

      // Every entry reads zero on both ports.
      for (int i = 0; i < DEPTH; i++) begin
         set_in(1'b0, '0, '0, AW'(i), AW'(DEPTH - 1 - i));
         cyc();
      end

      // r5 write then read; r6 untouched.
      set_in(1'b1, 5'd5, 32'hDEADBEEF, 5'd5, 5'd6);
      cyc();
      set_in(1'b0, '0, '0, 5'd5, 5'd6);
      cyc();

      // Same-cycle read of r7 on both ports: bypass vs old value.
      set_in(1'b1, 5'd7, 32'h12345678, 5'd7, 5'd7);
      cyc();
      set_in(1'b0, '0, '0, 5'd7, 5'd7);
      cyc();

      // r0 stays zero during and after a write.
      set_in(1'b1, 5'd0, 32'hFFFFFFFF, 5'd0, 5'd0);
      cyc();
      set_in(1'b0, '0, '0, 5'd0, 5'd5);
      cyc();

      // Random traffic.
      for (int i = 0; i < 60; i++) begin
         set_in(1'($urandom), AW'($urandom), DW'($urandom), AW'($urandom), AW'($urandom));
         cyc();
      end

      // Reset mid-clear restarts a full clear.
      set_in(1'b0, '0, '0, 5'd9, 5'd12);
      reset = 1'b1;
      cyc();
      reset = 1'b0;
      for (int i = 0; i < 10; i++) cyc();
      reset = 1'b1;
      cyc();
      reset = 1'b0;
      count_clear("clr_restart_len");
      for (int i = 0; i < DEPTH; i++) begin
         set_in(1'b0, '0, '0, AW'(i), AW'(i));
         cyc();
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

// File: doc/reg_file_param.md
# reg_file_param

Parametrised, clocked register file for the MIPS datapath, replacing the fixed 32×32 register file. It has one write port and two asynchronous read ports. Optional features are a hardwired zero register and write-to-read bypass. A reset-triggered clear sequencer zeroes every entry, one per cycle, and reports `init_busy` while it runs. The block sits between instruction decode (read addresses) and writeback (write port).

## Interface
- `DATA_W`, 32, width of each register in bits.
- `ADDR_W`, 5, address width; DEPTH = 2^ADDR_W entries.
- `ZERO_REG`, 1, when 1, entry 0 always reads 0 and writes to it are discarded.
- `BYPASS`, 1, when 1, a read of the address being written this cycle returns `wr_data`.
- `clk` in 1: single clock; all state changes on the rising edge.
- `reset` in 1: synchronous, active-high.
- `wr_en` in 1: write request, sampled at the rising edge.
- `wr_addr` in ADDR_W: write address.
- `wr_data` in DATA_W: write data.
- `rd_addr1` in ADDR_W: read port 1 address.
- `rd_addr2` in ADDR_W: read port 2 address.
- `rd_data1` out DATA_W: read port 1 data (combinational).
- `rd_data2` out DATA_W: read port 2 data (combinational).
- `init_busy` out 1: clear sequencer running; the register file is not usable while high.

## Operation
- Two states: CLEAR and READY. The sequencer uses a pointer `clr_ptr` of ADDR_W bits.
- Reset: any rising edge with `reset`=1 sets state to CLEAR and `clr_ptr` to 0. This applies in either state, including mid-clear, and the clear restarts from entry 0.
- CLEAR:
  - On each edge with `reset`=0, write 0 to entry `clr_ptr` and increment the pointer.
  - The edge that clears entry DEPTH-1 moves the state to READY.
  - The pointer wraps to 0 and is unused in READY.
- READY:
  - On an edge with `wr_en`=1, store `wr_data` at `wr_addr`.
  - Exception: with `ZERO_REG`=1 and `wr_addr`=0, the write is discarded.
- Writes while in CLEAR (`init_busy`=1) are dropped silently. They are not queued.
- Read priority, applied per port independently, highest first:
  - `init_busy`=1 → 0.
  - `ZERO_REG`=1 and address = 0 → 0.
  - `BYPASS`=1, `wr_en`=1, and `wr_addr` = read address → `wr_data`.
  - Otherwise → stored entry.
- Both read ports may carry the same address, and both may match the write address. Each port resolves independently and returns the same value.
- No arithmetic is performed. The data path is pure storage, with widths exactly DATA_W and no truncation or extension.

## Timing
- Reset values:
  - state = CLEAR, `clr_ptr` = 0, `init_busy` = 1.
  - `rd_data1` = `rd_data2` = 0.
  - Entry contents are don't-care until cleared.
- `init_busy` = (state == CLEAR). It is registered through the state, with no combinational path from inputs.
- Clear duration: `init_busy` stays high for exactly DEPTH rising edges after the first edge with `reset`=0 (32 edges at the defaults). It falls right after the edge that clears entry DEPTH-1.
- Write latency is one edge. Without bypass, data is visible on the read ports after the write edge.
- With `BYPASS`=1, data is visible combinationally in the same cycle as `wr_en`.
- Read latency is zero cycles (combinational from address and array).
- `reset` held high keeps the block in CLEAR at `clr_ptr`=0. Counting starts on the first edge with `reset` low.

## Test plan
- Clear sequence: assert `reset` for 2 cycles, then release. `init_busy` is 1 for exactly 32 edges, then 0. Afterwards, every address on both ports reads 0x00000000.
- Write/read: after init, write 0xDEADBEEF to r5. The next cycle, `rd_addr1`=5 → `rd_data1`=0xDEADBEEF. Meanwhile `rd_addr2`=6 → 0.
- Bypass and zero register (`BYPASS`=1):
  - With `wr_en`=1, `wr_addr`=7, `wr_data`=0x12345678, and `rd_addr1`=`rd_addr2`=7, both ports show 0x12345678 in the same cycle.
  - Write 0xFFFFFFFF to r0; `rd_addr1`=0 reads 0 during and after the write.
- Bypass disabled: with `BYPASS`=0 and the same write to r7, the read in the write cycle returns the old value (0). The new value appears the following cycle.
- Write during clear: issue a write of 0xAAAA5555 to r3 while `init_busy`=1. After init completes, r3 reads 0 and `rd_data` stays 0 throughout the busy period.
- Reset mid-clear: assert `reset` for 1 cycle at edge 10 of the clear. `clr_ptr` restarts at 0, and `init_busy` stays high for another full 32 edges after release.
